// File: rtl/bram_dma16_pkg.sv
// Shared definitions for the bram_dma16 block-copy/fill master.
// State encodings are plain 3-bit constants so older code that compares raw values keeps working.
package bram_dma16_pkg;

    localparam int unsigned StateWidth = 3;

    localparam logic [StateWidth-1:0] StIdle = 3'd0;
    localparam logic [StateWidth-1:0] StRd   = 3'd1;
    localparam logic [StateWidth-1:0] StWr   = 3'd2;
    localparam logic [StateWidth-1:0] StFill = 3'd3;
    localparam logic [StateWidth-1:0] StFin  = 3'd4;

endpackage

// File: rtl/bram_dma16.sv
// Single-port DMA master for one dbram16 port: block copy (2 cycles/word) and
// block fill (1 cycle/word), with abort and a one-cycle done pulse.
module bram_dma16 #(
    parameter int unsigned adr_width  = 11,
    parameter int unsigned data_width = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  cmd_start,
    input  logic                  cmd_fill,
    input  logic [adr_width-1:0]  cmd_src,
    input  logic [adr_width-1:0]  cmd_dst,
    input  logic [adr_width:0]    cmd_len,
    input  logic [data_width-1:0] cmd_pattern,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [adr_width:0]    count,
    output logic [adr_width-1:0]  m_a,
    output logic [data_width-1:0] m_do,
    output logic                  m_we,
    input  logic [data_width-1:0] m_di
);
    import bram_dma16_pkg::*;

    logic [StateWidth-1:0] state_q, state_d;
    logic [adr_width-1:0]  src_q, src_d;
    logic [adr_width-1:0]  dst_q, dst_d;
    logic [adr_width:0]    len_q, len_d;
    logic                  fill_q, fill_d;
    logic [data_width-1:0] pat_q, pat_d;
    logic [adr_width:0]    count_q, count_d;
    logic [adr_width-1:0]  ma_q, ma_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [adr_width:0]    count_inc;
    logic                  stop_now;

    assign count_inc = count_q + 1'b1;
    // A write cycle ends the command when it is the last word or abort is raised.
    assign stop_now  = abort || (count_inc == len_q);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        count_d = count_q;
        ma_d    = ma_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    len_d   = cmd_len;
                    fill_d  = cmd_fill;
                    pat_d   = cmd_pattern;
                    count_d = '0;
                    busy_d  = 1'b1;
                    if (cmd_len == '0) begin
                        state_d = StFin;
                    end else if (cmd_fill) begin
                        state_d = StFill;
                        ma_d    = cmd_dst;
                        we_d    = 1'b1;
                    end else begin
                        state_d = StRd;
                        ma_d    = cmd_src;
                    end
                end
            end
            StRd: begin
                if (abort) begin
                    state_d = StFin;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = StWr;
                    ma_d    = dst_q;
                    we_d    = 1'b1;
                end
            end
            StWr: begin
                count_d = count_inc;
                src_d   = src_q + 1'b1;
                dst_d   = dst_q + 1'b1;
                if (stop_now) begin
                    state_d = StFin;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = StRd;
                    ma_d    = src_q + 1'b1;
                end
            end
            StFill: begin
                count_d = count_inc;
                dst_d   = dst_q + 1'b1;
                if (stop_now) begin
                    state_d = StFin;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    ma_d = dst_q + 1'b1;
                    we_d = 1'b1;
                end
            end
            StFin: begin
                // A zero-length command arrives here still busy and pulses done on the way out.
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = busy_q;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= 1'b0;
            pat_q   <= '0;
            count_q <= '0;
            ma_q    <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            count_q <= count_d;
            ma_q    <= ma_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;
    assign m_a   = ma_q;
    assign m_we  = we_q;
    assign m_do  = fill_q ? pat_q : m_di;

endmodule

// File: tb/tb_bram_dma16.sv
// Bench for bram_dma16: an inline dual-port RAM answers on port a, port b preloads and reads back.
module tb_bram_dma16;
    localparam int AW    = 11;
    localparam int DW    = 16;
    localparam int DEPTH = 2048;

    typedef logic [AW-1:0] adr_t;
    typedef logic [AW:0]   len_t;
    typedef logic [DW-1:0] dat_t;
    typedef struct {
        adr_t a;
        dat_t d;
    } wr_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic cmd_start = 1'b0;
    logic cmd_fill = 1'b0;
    adr_t cmd_src = '0;
    adr_t cmd_dst = '0;
    len_t cmd_len = '0;
    dat_t cmd_pattern = '0;
    logic abort = 1'b0;
    logic busy, done, m_we;
    len_t count;
    adr_t m_a;
    dat_t m_do, m_di;

    dat_t ram [DEPTH];
    logic b_we = 1'b0;
    adr_t b_a = '0;
    dat_t b_d = '0;
    dat_t b_q;

    // Reference view of memory plus the expected access streams for the running command.
    dat_t mm [DEPTH];
    dat_t ovr [int];
    wr_t  wq [$];
    adr_t rq [$];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, mcount = 0, wr_cnt = 0, busy_cyc = 0, done_cnt = 0;
    int last_wr_cyc = 0, done_cyc = 0, rise_cyc = 0;
    logic busy_prev = 1'b0;

    bram_dma16 #(.adr_width(AW), .data_width(DW)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .cmd_start   (cmd_start),
        .cmd_fill    (cmd_fill),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_len     (cmd_len),
        .cmd_pattern (cmd_pattern),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .m_a         (m_a),
        .m_do        (m_do),
        .m_we        (m_we),
        .m_di        (m_di)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        m_di <= ram[m_a];
        if (m_we) ram[m_a] <= m_do;
        b_q <= ram[b_a];
        if (b_we) ram[b_a] <= b_d;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        wr_t w;
        cyc++;
        chk("count_track", int'(count), mcount);
        chk("busy_done_excl", int'(busy & done), 0);
        if (m_we) begin
            chk("we_implies_busy", int'(busy), 1);
            if (wq.size() == 0) begin
                chk("unexpected_write", int'(m_we), 0);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", int'(m_a), int'(w.a));
                chk("wr_data", int'(m_do), int'(w.d));
                mm[w.a] = w.d;
            end
            mcount++;
            wr_cnt++;
            last_wr_cyc = cyc;
        end else if (busy && rq.size() > 0) begin
            chk("rd_addr", int'(m_a), int'(rq.pop_front()));
        end
        if (busy) busy_cyc++;
        if (busy && !busy_prev) rise_cyc = cyc;
        busy_prev = busy;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pre(input adr_t a, input dat_t d);
        b_we = 1'b1;
        b_a  = a;
        b_d  = d;
        tick(1);
        b_we = 1'b0;
        mm[a] = d;
    endtask

    task automatic peek(input adr_t a, output dat_t d);
        b_a = a;
        tick(1);
        d = b_q;
    endtask

    task automatic expect_word(input string nm, input adr_t a, input int exp);
        dat_t d;
        peek(a, d);
        chk(nm, int'(d), exp);
    endtask

    task automatic check_mem(input string nm, input adr_t a, input int n);
        dat_t d;
        adr_t ad;
        for (int i = 0; i < n; i++) begin
            ad = a + adr_t'(i);
            peek(ad, d);
            chk(nm, int'(d), int'(mm[ad]));
        end
    endtask

    // Copy semantics: word i of dst takes word i of src as it stands after earlier writes.
    task automatic model_copy(input adr_t s, input adr_t d, input int n);
        adr_t ra, wa;
        dat_t v;
        ovr.delete();
        for (int i = 0; i < n; i++) begin
            ra = s + adr_t'(i);
            wa = d + adr_t'(i);
            v  = ovr.exists(int'(ra)) ? ovr[int'(ra)] : mm[ra];
            ovr[int'(wa)] = v;
            rq.push_back(ra);
            wq.push_back('{a: wa, d: v});
        end
    endtask

    task automatic model_fill(input adr_t d, input int n, input dat_t pat);
        for (int i = 0; i < n; i++) wq.push_back('{a: d + adr_t'(i), d: pat});
    endtask

    task automatic start(input logic fill, input adr_t s, input adr_t d, input int n,
                         input dat_t pat);
        if (fill) model_fill(d, n, pat);
        else      model_copy(s, d, n);
        tick(1);
        cmd_fill    = fill;
        cmd_src     = s;
        cmd_dst     = d;
        cmd_len     = len_t'(n);
        cmd_pattern = pat;
        cmd_start   = 1'b1;
        tick(1);
        cmd_start = 1'b0;
        mcount    = 0;
        wr_cnt    = 0;
        busy_cyc  = 0;
        done_cnt  = 0;
        // Command inputs are free to wander once accepted.
        cmd_fill    = ~fill;
        cmd_src     = ~s;
        cmd_dst     = ~d;
        cmd_len     = len_t'(7);
        cmd_pattern = ~pat;
    endtask

    task automatic finish_cmd(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge sys_clk);
            #1;
            k++;
        end
        chk("done_seen", done_cnt, 1);
        tick(3);
        chk("done_once", done_cnt, 1);
        chk("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        dat_t d;
        int wr_at_rst;

        tick(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_m_a", int'(m_a), 0);
        chk("rst_m_we", int'(m_we), 0);
        sys_rst = 1'b0;
        tick(2);

        // 1: fill 4 words of 0xBEEF at 0x010
        pre(11'h014, 16'h1234);
        start(1'b1, 11'h000, 11'h010, 4, 16'hBEEF);
        finish_cmd(20);
        chk("t1_count", int'(count), 4);
        chk("t1_busy_cycles", busy_cyc, 4);
        chk("t1_done_latency", done_cyc - last_wr_cyc, 1);
        chk("t1_wq_drained", wq.size(), 0);
        expect_word("t1_ram_010", 11'h010, 'hBEEF);
        expect_word("t1_ram_013", 11'h013, 'hBEEF);
        expect_word("t1_ram_014", 11'h014, 'h1234);

        // 2: copy 3 words 0x100 -> 0x200
        pre(11'h100, 16'd1);
        pre(11'h101, 16'd2);
        pre(11'h102, 16'd3);
        start(1'b0, 11'h100, 11'h200, 3, 16'h0000);
        finish_cmd(30);
        chk("t2_count", int'(count), 3);
        chk("t2_busy_cycles", busy_cyc, 6);
        chk("t2_done_latency", done_cyc - last_wr_cyc, 1);
        chk("t2_wq_drained", wq.size(), 0);
        expect_word("t2_ram_200", 11'h200, 1);
        expect_word("t2_ram_201", 11'h201, 2);
        expect_word("t2_ram_202", 11'h202, 3);

        // 3: wrapping copy 0x7FE -> 0x000, overlapping so words replicate
        pre(11'h7FE, 16'hAAAA);
        pre(11'h7FF, 16'h5555);
        pre(11'h000, 16'h1111);
        pre(11'h001, 16'h2222);
        start(1'b0, 11'h7FE, 11'h000, 4, 16'h0000);
        finish_cmd(30);
        chk("t3_count", int'(count), 4);
        chk("t3_rq_drained", rq.size(), 0);
        expect_word("t3_ram_000", 11'h000, 'hAAAA);
        expect_word("t3_ram_001", 11'h001, 'h5555);
        expect_word("t3_ram_002", 11'h002, 'hAAAA);
        expect_word("t3_ram_003", 11'h003, 'h5555);

        // 4: zero-length command
        start(1'b1, 11'h000, 11'h050, 0, 16'hFFFF);
        finish_cmd(10);
        chk("t4_count", int'(count), 0);
        chk("t4_writes", wr_cnt, 0);
        chk("t4_busy_cycles", busy_cyc, 1);
        chk("t4_done_after_busy", done_cyc - rise_cyc, 1);

        // 5: fill 100, abort on the 10th write, a second start while busy is ignored
        pre(11'h30A, 16'h0BAD);
        start(1'b1, 11'h000, 11'h300, 100, 16'h5A5A);
        tick(2);
        cmd_fill  = 1'b0;
        cmd_len   = len_t'(5);
        cmd_start = 1'b1;
        tick(1);
        cmd_start = 1'b0;
        tick(6);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        finish_cmd(10);
        chk("t5_count", int'(count), 10);
        chk("t5_writes", wr_cnt, 10);
        chk("t5_done_latency", done_cyc - last_wr_cyc, 1);
        wq.delete();
        expect_word("t5_ram_309", 11'h309, 'h5A5A);
        expect_word("t5_ram_30a", 11'h30A, 'h0BAD);

        // 6: reset in the middle of a 50-word copy, then a fresh command
        for (int i = 0; i < 50; i++) pre(adr_t'(11'h400 + i), dat_t'(16'h1000 + i));
        start(1'b0, 11'h400, 11'h500, 50, 16'h0000);
        tick(20);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        mcount  = 0;
        wr_at_rst = wr_cnt;
        rq.delete();
        wq.delete();
        chk("t6_rst_we", int'(m_we), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_count", int'(count), 0);
        done_cnt = 0;
        tick(60);
        chk("t6_no_done", done_cnt, 0);
        chk("t6_partial_writes", int'(wr_at_rst > 0 && wr_at_rst < 50), 1);
        check_mem("t6_partial_mem", 11'h500, wr_at_rst);
        start(1'b0, 11'h400, 11'h600, 5, 16'h0000);
        finish_cmd(30);
        chk("t6_count", int'(count), 5);
        expect_word("t6_ram_600", 11'h600, 'h1000);
        expect_word("t6_ram_604", 11'h604, 'h1004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
